// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   t_word        : 32-bit bus word / address type
//   t_opcode      : 5-bit major opcode held in instruction bits [31:27]
//   t_fetch_state : fetch sequencer states (FETCH, FLUSH, HALTED)
//   nop_word()    : the canonical NOP instruction word
package fetch_stage_pkg;

  typedef logic [31:0] t_word;

  typedef enum logic [4:0] {
    OPCODE_LOAD   = 5'h01,
    OPCODE_STORE  = 5'h02,
    OPCODE_BRANCH = 5'h03,
    OPCODE_JUMP   = 5'h04,
    OPCODE_NOP    = 5'h1F
  } t_opcode;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } t_fetch_state;

  function automatic t_word nop_word();
    return {OPCODE_NOP, 27'h0};
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register for the fetch stage.
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset, loads RESET_PC
//   load       : load load_value (word-aligned) this edge; highest priority
//   load_value : redirect target; bits [1:0] are forced to zero
//   increment  : advance by one word (wraps 0xFFFF_FFFC -> 0x0000_0000)
//   pc         : current program counter
module program_counter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        increment,
  output logic [31:0] pc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value & 32'hFFFF_FFFC;
    end else if (increment) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage at the head of the pipeline.
// Owns the PC, reads instructions over the shared bus whenever stage 1 does
// not need it, handles branch/jump redirects by squashing FLUSH_DEPTH slots
// with NOPs, and freezes in HALTED until reset.
//   reset                : asynchronous active-high reset
//   clock                : rising-edge clock
//   memory_access_cycle  : stage 1 owns the bus this cycle
//   new_pc_valid/new_pc  : redirect request and target
//   halt                 : freeze fetch until reset
//   fetch_data           : instruction word returned by the bus
//   fetch_address        : bus address (always the PC)
//   fetch_read           : instruction read request (combinational)
//   outbound_instruction : instruction handed to stage 1
//   outbound_pc          : address of the last real (non-NOP) instruction
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        memory_access_cycle,
  input  logic        new_pc_valid,
  input  logic [31:0] new_pc,
  input  logic        halt,
  input  logic [31:0] fetch_data,
  output logic [31:0] fetch_address,
  output logic        fetch_read,
  output logic [31:0] outbound_instruction,
  output logic [31:0] outbound_pc
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

  t_fetch_state state;
  logic [2:0]   flush_count;
  logic [31:0]  pc;
  logic         redirect;

  // A halted stage ignores redirects, so the PC must not load either.
  assign redirect      = new_pc_valid && (state != HALTED);
  assign fetch_read    = (state == FETCH) && !memory_access_cycle &&
                         !new_pc_valid && !halt;
  assign fetch_address = pc;

  // The PC advances exactly on edges that complete a real fetch.
  program_counter #(
    .RESET_PC(RESET_PC)
  ) u_program_counter (
    .clock     (clock),
    .reset     (reset),
    .load      (redirect),
    .load_value(new_pc),
    .increment (fetch_read),
    .pc        (pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= FETCH;
      flush_count          <= '0;
      outbound_instruction <= nop_word();
      outbound_pc          <= RESET_PC;
    end else if (redirect) begin
      outbound_instruction <= nop_word();
      if (FLUSH_DEPTH > 1) begin
        state       <= FLUSH;
        flush_count <= FLUSH_RELOAD;
      end else begin
        state       <= FETCH;
        flush_count <= '0;
      end
    end else if (halt) begin
      state                <= HALTED;
      outbound_instruction <= nop_word();
    end else if (state == HALTED) begin
      outbound_instruction <= nop_word();
    end else if (state == FLUSH) begin
      // The redirect cycle was the first NOP slot, so the last flush
      // cycle is the one that sees a count of 1.
      outbound_instruction <= nop_word();
      flush_count          <= flush_count - 3'd1;
      if (flush_count == 3'd1) begin
        state <= FETCH;
      end
    end else if (memory_access_cycle) begin
      outbound_instruction <= nop_word();
    end else begin
      outbound_instruction <= fetch_data;
      outbound_pc          <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP     = {OPCODE_NOP, 27'h0};
  localparam logic [31:0] RPC_A   = 32'h0000_0000;
  localparam logic [31:0] RPC_B   = 32'hFFFF_FFFC;
  localparam int unsigned DEPTH_A = 2;
  localparam int unsigned DEPTH_B = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memory_access_cycle = 1'b0;
  logic        new_pc_valid = 1'b0;
  logic [31:0] new_pc = '0;
  logic        halt = 1'b0;

  logic [31:0] fetch_data_a, fetch_address_a, outbound_instruction_a, outbound_pc_a;
  logic        fetch_read_a;
  logic [31:0] fetch_data_b, fetch_address_b, outbound_instruction_b, outbound_pc_b;
  logic        fetch_read_b;

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign fetch_data_a = word_at(fetch_address_a);
  assign fetch_data_b = word_at(fetch_address_b);

  fetch_stage #(.RESET_PC(RPC_A), .FLUSH_DEPTH(DEPTH_A)) dut_a (
    .reset(reset), .clock(clock), .memory_access_cycle(memory_access_cycle),
    .new_pc_valid(new_pc_valid), .new_pc(new_pc), .halt(halt),
    .fetch_data(fetch_data_a), .fetch_address(fetch_address_a),
    .fetch_read(fetch_read_a), .outbound_instruction(outbound_instruction_a),
    .outbound_pc(outbound_pc_a)
  );

  fetch_stage #(.RESET_PC(RPC_B), .FLUSH_DEPTH(DEPTH_B)) dut_b (
    .reset(reset), .clock(clock), .memory_access_cycle(memory_access_cycle),
    .new_pc_valid(new_pc_valid), .new_pc(new_pc), .halt(halt),
    .fetch_data(fetch_data_b), .fetch_address(fetch_address_b),
    .fetch_read(fetch_read_b), .outbound_instruction(outbound_instruction_b),
    .outbound_pc(outbound_pc_b)
  );

  // Reference model: a PC, the last emitted slot, the last real fetch
  // address, how many squash slots remain, and whether we are frozen.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] out;
    logic [31:0] opc;
    int unsigned flush_left;
    bit          halted;
  } model_t;

  model_t ma, mb;
  int tests_run = 0;
  int failures  = 0;

  logic        rd_a_obs, rd_b_obs;
  bit          rd_a_exp, rd_b_exp;
  logic [31:0] addr_a_obs, addr_b_obs, addr_a_exp, addr_b_exp;

  function automatic model_t model_reset(input logic [31:0] rpc);
    model_t m;
    m.pc = rpc; m.out = NOP; m.opc = rpc; m.flush_left = 0; m.halted = 0;
    return m;
  endfunction

  function automatic bit model_reads(input model_t m, input bit mem, input bit npv, input bit hlt);
    return !m.halted && (m.flush_left == 0) && !mem && !npv && !hlt;
  endfunction

  function automatic model_t model_next(input model_t m, input bit mem, input bit npv,
                                        input logic [31:0] npc, input bit hlt,
                                        input int unsigned depth);
    model_t n = m;
    if (!m.halted && npv) begin
      n.pc = npc & 32'hFFFF_FFFC; n.out = NOP; n.flush_left = depth - 1;
    end else if (hlt) begin
      n.halted = 1; n.out = NOP;
    end else if (m.halted) begin
      n.out = NOP;
    end else if (m.flush_left != 0) begin
      n.out = NOP; n.flush_left = m.flush_left - 1;
    end else if (mem) begin
      n.out = NOP;
    end else begin
      n.out = word_at(m.pc); n.opc = m.pc; n.pc = m.pc + 32'd4;
    end
    return n;
  endfunction

  // One clock cycle: drive inputs, sample bus outputs mid-cycle, advance
  // the models, then return 1ns after the rising edge.
  task automatic step(input bit mem, input bit npv, input logic [31:0] npc, input bit hlt);
    memory_access_cycle = mem; new_pc_valid = npv; new_pc = npc; halt = hlt;
    @(negedge clock);
    rd_a_obs = fetch_read_a; addr_a_obs = fetch_address_a;
    rd_b_obs = fetch_read_b; addr_b_obs = fetch_address_b;
    rd_a_exp = model_reads(ma, mem, npv, hlt); addr_a_exp = ma.pc;
    rd_b_exp = model_reads(mb, mem, npv, hlt); addr_b_exp = mb.pc;
    ma = model_next(ma, mem, npv, npc, hlt, DEPTH_A);
    mb = model_next(mb, mem, npv, npc, hlt, DEPTH_B);
    @(posedge clock); #1;
    memory_access_cycle = 1'b0; new_pc_valid = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; #1;
    tests_run++; if (outbound_instruction_a !== NOP) begin failures++; $display("FAIL reset.out_a got %h want %h", outbound_instruction_a, NOP); end
    tests_run++; if (outbound_pc_a !== RPC_A) begin failures++; $display("FAIL reset.opc_a got %h want %h", outbound_pc_a, RPC_A); end
    tests_run++; if (fetch_address_a !== RPC_A) begin failures++; $display("FAIL reset.addr_a got %h want %h", fetch_address_a, RPC_A); end
    tests_run++; if (outbound_pc_b !== RPC_B) begin failures++; $display("FAIL reset.opc_b got %h want %h", outbound_pc_b, RPC_B); end
    tests_run++; if (fetch_address_b !== RPC_B) begin failures++; $display("FAIL reset.addr_b got %h want %h", fetch_address_b, RPC_B); end
    reset = 1'b0;
    ma = model_reset(RPC_A); mb = model_reset(RPC_B);
  endtask

  task automatic test_straight_line;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i) * 32'd4;
      step(0, 0, '0, 0);
      tests_run++; if (rd_a_obs !== 1'b1) begin failures++; $display("FAIL straight.read c%0d got %b want 1", i, rd_a_obs); end
      tests_run++; if (addr_a_obs !== a) begin failures++; $display("FAIL straight.addr c%0d got %h want %h", i, addr_a_obs, a); end
      tests_run++; if (outbound_instruction_a !== 32'h1000_0000 + a) begin failures++; $display("FAIL straight.out c%0d got %h want %h", i, outbound_instruction_a, 32'h1000_0000 + a); end
      tests_run++; if (outbound_pc_a !== a) begin failures++; $display("FAIL straight.opc c%0d got %h want %h", i, outbound_pc_a, a); end
      if (i == 1) begin
        tests_run++; if (addr_b_obs !== 32'h0) begin failures++; $display("FAIL wrap.addr_b got %h want 00000000", addr_b_obs); end
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] held;
    logic [31:0] opc_before;
    held = ma.pc; opc_before = ma.opc;
    step(1, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL stall.read got %b want 0", rd_a_obs); end
    tests_run++; if (outbound_instruction_a !== NOP) begin failures++; $display("FAIL stall.out got %h want %h", outbound_instruction_a, NOP); end
    tests_run++; if (fetch_address_a !== held) begin failures++; $display("FAIL stall.pc got %h want %h", fetch_address_a, held); end
    tests_run++; if (outbound_pc_a !== opc_before) begin failures++; $display("FAIL stall.opc got %h want %h", outbound_pc_a, opc_before); end
    step(0, 0, '0, 0);
    tests_run++; if (outbound_instruction_a !== word_at(held)) begin failures++; $display("FAIL stall.resume got %h want %h", outbound_instruction_a, word_at(held)); end
    tests_run++; if (outbound_pc_b !== mb.opc) begin failures++; $display("FAIL stall.opc_b got %h want %h", outbound_pc_b, mb.opc); end
  endtask

  task automatic test_redirect;
    int guard = 0;
    while (ma.pc != 32'h10 && guard < 16) begin step(0, 0, '0, 0); guard++; end
    tests_run++; if (ma.pc != 32'h10) begin failures++; $display("FAIL redirect.reach got %h want 00000010", ma.pc); end
    step(0, 1, 32'h0000_0103, 0);
    tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL redirect.read got %b want 0", rd_a_obs); end
    tests_run++; if (outbound_instruction_a !== NOP) begin failures++; $display("FAIL redirect.slot1 got %h want %h", outbound_instruction_a, NOP); end
    tests_run++; if (fetch_address_a !== 32'h100) begin failures++; $display("FAIL redirect.pc got %h want 00000100", fetch_address_a); end
    step(0, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL redirect.flush_read got %b want 0", rd_a_obs); end
    tests_run++; if (outbound_instruction_a !== NOP) begin failures++; $display("FAIL redirect.slot2 got %h want %h", outbound_instruction_a, NOP); end
    step(0, 0, '0, 0);
    tests_run++; if (addr_a_obs !== 32'h100 || rd_a_obs !== 1'b1) begin failures++; $display("FAIL redirect.fetch got %h/%b want 00000100/1", addr_a_obs, rd_a_obs); end
    tests_run++; if (outbound_instruction_a !== word_at(32'h100)) begin failures++; $display("FAIL redirect.out got %h want %h", outbound_instruction_a, word_at(32'h100)); end
    tests_run++; if (outbound_pc_a !== 32'h100) begin failures++; $display("FAIL redirect.opc got %h want 00000100", outbound_pc_a); end
    tests_run++; if (outbound_instruction_b !== mb.out) begin failures++; $display("FAIL redirect.out_b got %h want %h", outbound_instruction_b, mb.out); end
    step(0, 0, '0, 0);
    tests_run++; if (outbound_instruction_b !== mb.out) begin failures++; $display("FAIL redirect.depth3_b got %h want %h", outbound_instruction_b, mb.out); end
  endtask

  task automatic test_redirect_stall;
    step(1, 1, 32'h40, 0);
    tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL rstall.read got %b want 0", rd_a_obs); end
    tests_run++; if (fetch_address_a !== 32'h40) begin failures++; $display("FAIL rstall.pc got %h want 00000040", fetch_address_a); end
    step(0, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL rstall.flush got %b want 0", rd_a_obs); end
    step(0, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b1 || addr_a_obs !== 32'h40) begin failures++; $display("FAIL rstall.fetch got %b/%h want 1/00000040", rd_a_obs, addr_a_obs); end
  endtask

  task automatic test_flush_restart;
    step(0, 1, 32'h200, 0);
    step(0, 1, 32'h302, 0);
    step(0, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL restart.reload got %b want 0", rd_a_obs); end
    step(0, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b1 || addr_a_obs !== 32'h300) begin failures++; $display("FAIL restart.fetch got %b/%h want 1/00000300", rd_a_obs, addr_a_obs); end
    tests_run++; if (rd_b_obs !== rd_b_exp) begin failures++; $display("FAIL restart.read_b got %b want %b", rd_b_obs, rd_b_exp); end
  endtask

  task automatic test_random;
    bit mem, npv;
    logic [31:0] npc;
    for (int i = 0; i < 200; i++) begin
      mem = ($urandom_range(0, 3) == 0);
      npv = ($urandom_range(0, 7) == 0);
      npc = $urandom;
      step(mem, npv, npc, 0);
      tests_run++; if (rd_a_obs !== rd_a_exp) begin failures++; $display("FAIL rand.read_a c%0d got %b want %b", i, rd_a_obs, rd_a_exp); end
      tests_run++; if (addr_a_obs !== addr_a_exp) begin failures++; $display("FAIL rand.addr_a c%0d got %h want %h", i, addr_a_obs, addr_a_exp); end
      tests_run++; if (outbound_instruction_a !== ma.out) begin failures++; $display("FAIL rand.out_a c%0d got %h want %h", i, outbound_instruction_a, ma.out); end
      tests_run++; if (outbound_pc_a !== ma.opc) begin failures++; $display("FAIL rand.opc_a c%0d got %h want %h", i, outbound_pc_a, ma.opc); end
      tests_run++; if (rd_b_obs !== rd_b_exp) begin failures++; $display("FAIL rand.read_b c%0d got %b want %b", i, rd_b_obs, rd_b_exp); end
      tests_run++; if (addr_b_obs !== addr_b_exp) begin failures++; $display("FAIL rand.addr_b c%0d got %h want %h", i, addr_b_obs, addr_b_exp); end
      tests_run++; if (outbound_instruction_b !== mb.out) begin failures++; $display("FAIL rand.out_b c%0d got %h want %h", i, outbound_instruction_b, mb.out); end
      tests_run++; if (outbound_pc_b !== mb.opc) begin failures++; $display("FAIL rand.opc_b c%0d got %h want %h", i, outbound_pc_b, mb.opc); end
    end
  endtask

  task automatic test_reset_mid_flush;
    step(0, 1, 32'h500, 0);
    #2; reset = 1'b1; #1;
    tests_run++; if (outbound_instruction_a !== NOP) begin failures++; $display("FAIL midflush.out got %h want %h", outbound_instruction_a, NOP); end
    tests_run++; if (fetch_address_a !== RPC_A) begin failures++; $display("FAIL midflush.pc got %h want %h", fetch_address_a, RPC_A); end
    tests_run++; if (outbound_pc_b !== RPC_B) begin failures++; $display("FAIL midflush.opc_b got %h want %h", outbound_pc_b, RPC_B); end
    reset = 1'b0;
    ma = model_reset(RPC_A); mb = model_reset(RPC_B);
    step(0, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b1 || addr_a_obs !== RPC_A) begin failures++; $display("FAIL midflush.first got %b/%h want 1/%h", rd_a_obs, addr_a_obs, RPC_A); end
    tests_run++; if (outbound_instruction_b !== word_at(RPC_B)) begin failures++; $display("FAIL midflush.out_b got %h want %h", outbound_instruction_b, word_at(RPC_B)); end
  endtask

  task automatic test_halt;
    logic [31:0] held;
    step(0, 0, '0, 0);
    held = ma.pc;
    step(0, 0, '0, 1);
    tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL halt.read got %b want 0", rd_a_obs); end
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, 0);
      tests_run++; if (rd_a_obs !== 1'b0) begin failures++; $display("FAIL halt.read c%0d got %b want 0", i, rd_a_obs); end
      tests_run++; if (outbound_instruction_a !== NOP) begin failures++; $display("FAIL halt.out c%0d got %h want %h", i, outbound_instruction_a, NOP); end
      tests_run++; if (fetch_address_a !== held) begin failures++; $display("FAIL halt.pc c%0d got %h want %h", i, fetch_address_a, held); end
      tests_run++; if (fetch_address_b !== mb.pc) begin failures++; $display("FAIL halt.pc_b c%0d got %h want %h", i, fetch_address_b, mb.pc); end
    end
    reset = 1'b1; #1;
    tests_run++; if (fetch_address_a !== RPC_A) begin failures++; $display("FAIL halt.reset_pc got %h want %h", fetch_address_a, RPC_A); end
    reset = 1'b0;
    ma = model_reset(RPC_A); mb = model_reset(RPC_B);
    step(0, 0, '0, 0);
    tests_run++; if (rd_a_obs !== 1'b1) begin failures++; $display("FAIL halt.exit_read got %b want 1", rd_a_obs); end
    tests_run++; if (outbound_instruction_a !== word_at(RPC_A)) begin failures++; $display("FAIL halt.exit_out got %h want %h", outbound_instruction_a, word_at(RPC_A)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_flush_restart();
    test_random();
    test_reset_mid_flush();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
